if_id_skid_stage: RTL and testbench
===================================

// Module: if_id_skid_stage
// PURPOSE
//  Parametrised IF/ID pipeline stage with valid/ready handshake, 2-entry skid buffer,
//  synchronous flush with NOP injection and a bubble counter. Sits between fetch
//  and decode; carries {pc+1, instruction}. Provides backpressure without
//  combinational ready paths and squashes wrong-path fetches on branch.
// PARAMETERS
//  PC_W      32            width of pc+1 payload
//  INSTR_W   32            width of instruction payload
//  NOP_INSTR {INSTR_W{1'b0}} instruction driven when stage holds no valid entry
//  SKID      1             1 = 2-entry skid (registered in_ready); 0 = single entry
//  CNT_W     16            width of bubble counter
// PORTS
//  Clk        in   1        clock, rising edge
//  Reset      in   1        asynchronous, active-low reset
//  in_valid   in   1        fetch presents payload
//  in_ready   out  1        stage accepts payload this cycle
//  in_pc      in   PC_W     pc+1 from fetch
//  in_instr   in   INSTR_W  instruction from fetch
//  flush      in   1        squash all held entries (branch taken / exception)
//  out_valid  out  1        decode-side payload valid
//  out_ready  in   1        decode consumes payload this cycle
//  out_pc     out  PC_W     held pc+1
//  out_instr  out  INSTR_W  held instruction, NOP_INSTR when !out_valid
//  bubble_cnt out  CNT_W    cycles with out_valid==0 since reset, saturating
// BEHAVIOUR
//  - Reset low (async): out_valid=0, skid empty, in_ready=1, out_pc=0,
//    out_instr=NOP_INSTR, skid regs=0, bubble_cnt=0. All state regs reset.
//  - Accept = in_valid&in_ready; Send = out_valid&out_ready. Latency 1 cycle,
//    throughput 1/cycle when out_ready held high. Order strictly preserved.
//  - SKID=1: states EMPTY, ONE (main valid), FULL (main+skid valid).
//    in_ready = (state!=FULL), registered, no comb path from out_ready.
//    EMPTY: Accept -> ONE, main<=in.
//    ONE: Accept&Send -> ONE, main<=in; Accept&!Send -> FULL, skid<=in;
//         !Accept&Send -> EMPTY; else hold.
//    FULL: Send -> ONE, main<=skid; else hold. No Accept possible.
//  - SKID=0: states EMPTY, ONE only; in_ready = !out_valid | out_ready
//    (combinational); ONE with Accept&!Send impossible.
//  - Hold: with !Send and no flush, out_pc/out_instr/out_valid stable (no bubble
//    overwrite, no drop).
//  - flush=1 (sync, highest priority): next state EMPTY, main and skid invalid,
//    out_instr<=NOP_INSTR, out_pc<=0. Payload offered in flush cycle is dropped
//    even if in_ready=1. A Send in the flush cycle still counts as consumed.
//  - Flush in FULL: both entries dropped; in_ready=1 next cycle.
//  - bubble_cnt: +1 each cycle out_valid==0; saturates at all-ones, no wrap;
//    not cleared by flush; only Reset clears it.
//  - Reset asserted mid-transfer: all entries lost immediately, outputs at reset
//    values while Reset low; first Accept possible on first edge after release.
// TESTING
//  1 Reset low then high, idle 5 cycles -> out_valid=0, out_instr=NOP_INSTR,
//    in_ready=1, bubble_cnt=5.
//  2 Stream pc 1..4 / instr 0xA1..0xA4, out_ready=1 -> out_valid 1 cycle after
//    each accept, outputs 0xA1..0xA4 in order, no gaps.
//  3 SKID=1: accept 0xB1, out_ready=0, offer 0xB2 -> state FULL, in_ready=0,
//    out_instr=0xB1 held; raise out_ready -> 0xB1 then 0xB2, in_ready back to 1.
//  4 FULL with 0xC1/0xC2, assert flush with in_valid=1 instr 0xC3 -> next cycle
//    out_valid=0, out_instr=NOP_INSTR, out_pc=0; 0xC3 never appears.
//  5 CNT_W=4, idle 20 cycles after reset -> bubble_cnt saturates at 15.
//  6 SKID=0: ONE with out_ready=0 -> in_ready=0; out_ready=1, in_valid=1 same
//    cycle -> accept and send together, state stays ONE.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage: valid/ready handshake with an optional 2-entry skid
// buffer, synchronous flush that injects NOP, and a saturating bubble counter.
// The payload is {pc+1, instruction}. When SKID=1, in_ready is taken straight
// from a register, so there is no combinational path from out_ready to in_ready.
module if_id_skid_stage #(
   parameter int unsigned         PC_W      = 32,
   parameter int unsigned         INSTR_W   = 32,
   parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
   parameter int unsigned         SKID      = 1,
   parameter int unsigned         CNT_W     = 16
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic [CNT_W-1:0]   bubble_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_out_valid;
   logic                 r_in_ready;
   logic [PC_W-1:0]      r_main_pc;
   logic [INSTR_W-1:0]   r_main_instr;
   logic [PC_W-1:0]      r_skid_pc;
   logic [INSTR_W-1:0]   r_skid_instr;
   logic [CNT_W-1:0]     r_bubble;

   logic                 w_accept;
   logic                 w_send;

   // SKID=1 uses the registered ready; SKID=0 lets a consuming decode refill in the same cycle
   assign in_ready  = (SKID != 0) ? r_in_ready : (!r_out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_send    = r_out_valid && out_ready;

   assign out_valid  = r_out_valid;
   assign out_pc     = r_main_pc;
   assign out_instr  = r_main_instr;
   assign bubble_cnt = r_bubble;

   // Handshake FSM: main/skid entries, registered out_valid and in_ready
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state      <= ST_EMPTY;
         r_out_valid  <= 1'b0;
         r_in_ready   <= 1'b1;
         r_main_pc    <= '0;
         r_main_instr <= NOP_INSTR;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
      end else if (flush) begin
         // Squash everything held, including any payload offered this cycle
         r_state      <= ST_EMPTY;
         r_out_valid  <= 1'b0;
         r_in_ready   <= 1'b1;
         r_main_pc    <= '0;
         r_main_instr <= NOP_INSTR;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_state      <= ST_ONE;
                  r_out_valid  <= 1'b1;
                  r_main_pc    <= in_pc;
                  r_main_instr <= in_instr;
               end
            end
            ST_ONE: begin
               if (w_accept && w_send) begin
                  r_main_pc    <= in_pc;
                  r_main_instr <= in_instr;
               end else if (w_accept) begin
                  // Only reachable with SKID=1: decode stalled, park the new entry
                  r_state      <= ST_FULL;
                  r_in_ready   <= 1'b0;
                  r_skid_pc    <= in_pc;
                  r_skid_instr <= in_instr;
               end else if (w_send) begin
                  r_state      <= ST_EMPTY;
                  r_out_valid  <= 1'b0;
                  r_main_pc    <= '0;
                  r_main_instr <= NOP_INSTR;
               end
            end
            ST_FULL: begin
               if (w_send) begin
                  r_state      <= ST_ONE;
                  r_in_ready   <= 1'b1;
                  r_main_pc    <= r_skid_pc;
                  r_main_instr <= r_skid_instr;
                  r_skid_pc    <= '0;
                  r_skid_instr <= '0;
               end
            end
            default: begin
               r_state      <= ST_EMPTY;
               r_out_valid  <= 1'b0;
               r_in_ready   <= 1'b1;
               r_main_pc    <= '0;
               r_main_instr <= NOP_INSTR;
            end
         endcase
      end
   end

   // Saturating count of cycles without a valid output; only reset clears it
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_bubble <= '0;
      end else if (!r_out_valid && (r_bubble != '1)) begin
         r_bubble <= r_bubble + 1'b1;
      end
   end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: one SKID=1 instance (non-zero NOP) and one
// SKID=0 instance with a 4-bit bubble counter, each with a payload scoreboard.
module tb_if_id_skid_stage;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] NOP0 = 32'h0000_0000;

   logic        Clk = 1'b0;
   logic        Reset;

   // SKID=1 instance signals
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_pc, in_instr, out_pc, out_instr;
   logic [15:0] bubble_cnt;

   // SKID=0 instance signals
   logic        in0_valid, in0_ready, flush0, out0_valid, out0_ready;
   logic [31:0] in0_pc, in0_instr, out0_pc, out0_instr;
   logic [3:0]  bubble0_cnt;

   int n_total = 0;
   int n_bad   = 0;

   logic [63:0] q1[$];
   logic [63:0] q0[$];
   logic [15:0] m_bub1;
   logic [3:0]  m_bub0;

   always #5 Clk = ~Clk;

   if_id_skid_stage #(
      .PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .SKID(1), .CNT_W(16)
   ) u_dut (
      .Clk(Clk), .Reset(Reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .bubble_cnt(bubble_cnt)
   );

   if_id_skid_stage #(
      .PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP0), .SKID(0), .CNT_W(4)
   ) u_dut0 (
      .Clk(Clk), .Reset(Reset),
      .in_valid(in0_valid), .in_ready(in0_ready), .in_pc(in0_pc), .in_instr(in0_instr),
      .flush(flush0),
      .out_valid(out0_valid), .out_ready(out0_ready), .out_pc(out0_pc), .out_instr(out0_instr),
      .bubble_cnt(bubble0_cnt)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Scoreboards and bubble models, sampled mid-cycle while inputs are stable
   always @(negedge Clk) begin
      if (!Reset) begin
         q1.delete();
         q0.delete();
         m_bub1 = '0;
         m_bub0 = '0;
      end else begin
         if (out_valid && out_ready) begin
            if (q1.size() == 0) check_val("sb1_extra", {out_pc, out_instr}, 64'd0);
            else check_val("sb1_data", {out_pc, out_instr}, q1.pop_front());
         end
         if (flush) q1.delete();
         else if (in_valid && in_ready) q1.push_back({in_pc, in_instr});
         if (!out_valid) check_val("nop1", {32'd0, out_instr}, {32'd0, NOP});
         if (!out_valid && m_bub1 != 16'hFFFF) m_bub1 = m_bub1 + 16'd1;

         if (out0_valid && out0_ready) begin
            if (q0.size() == 0) check_val("sb0_extra", {out0_pc, out0_instr}, 64'd0);
            else check_val("sb0_data", {out0_pc, out0_instr}, q0.pop_front());
         end
         if (flush0) q0.delete();
         else if (in0_valid && in0_ready) q0.push_back({in0_pc, in0_instr});
         if (!out0_valid && m_bub0 != 4'hF) m_bub0 = m_bub0 + 4'd1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b0;
      in_valid = 0; in_pc = '0; in_instr = '0; flush = 0; out_ready = 0;
      in0_valid = 0; in0_pc = '0; in0_instr = '0; flush0 = 0; out0_ready = 0;

      // Reset state
      repeat (2) @(posedge Clk);
      #1;
      check_val("rst_valid", {63'd0, out_valid}, 64'd0);
      check_val("rst_ready", {63'd0, in_ready}, 64'd1);
      check_val("rst_instr", {32'd0, out_instr}, {32'd0, NOP});
      check_val("rst_pc", {32'd0, out_pc}, 64'd0);
      check_val("rst_bub", {48'd0, bubble_cnt}, 64'd0);
      Reset = 1'b1;

      // Idle: bubble counting and 4-bit saturation
      repeat (5) tick();
      check_val("idle_bub5", {48'd0, bubble_cnt}, 64'd5);
      check_val("idle_bub5_0", {60'd0, bubble0_cnt}, 64'd5);
      check_val("idle_ready", {63'd0, in_ready}, 64'd1);
      repeat (15) tick();
      check_val("sat_bub0", {60'd0, bubble0_cnt}, 64'd15);
      check_val("idle_bub20", {48'd0, bubble_cnt}, 64'd20);

      // Back-to-back stream, one result per cycle
      out_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1; in_pc = i; in_instr = 32'hA0 + i;
         tick();
         check_val("str_valid", {63'd0, out_valid}, 64'd1);
         check_val("str_instr", {32'd0, out_instr}, {32'd0, 32'hA0 + i});
      end
      in_valid = 0;
      repeat (2) tick();
      check_val("str_drain", {63'd0, out_valid}, 64'd0);

      // Skid fill and drain
      out_ready = 0;
      in_valid = 1; in_pc = 32'h11; in_instr = 32'hB1;
      tick();
      in_pc = 32'h12; in_instr = 32'hB2;
      tick();
      check_val("full_ready", {63'd0, in_ready}, 64'd0);
      in_pc = 32'h13; in_instr = 32'hB3;
      tick();
      in_valid = 0;
      tick();
      check_val("full_hold", {32'd0, out_instr}, {32'd0, 32'hB1});
      check_val("full_holdv", {63'd0, out_valid}, 64'd1);
      out_ready = 1;
      tick();
      check_val("full_b2", {32'd0, out_instr}, {32'd0, 32'hB2});
      check_val("full_rdy1", {63'd0, in_ready}, 64'd1);
      tick();
      check_val("full_empty", {63'd0, out_valid}, 64'd0);

      // Flush while FULL with a payload offered
      out_ready = 0;
      in_valid = 1; in_pc = 32'h21; in_instr = 32'hC1;
      tick();
      in_pc = 32'h22; in_instr = 32'hC2;
      tick();
      in_pc = 32'h23; in_instr = 32'hC3; flush = 1;
      tick();
      flush = 0; in_valid = 0;
      check_val("fl_valid", {63'd0, out_valid}, 64'd0);
      check_val("fl_instr", {32'd0, out_instr}, {32'd0, NOP});
      check_val("fl_pc", {32'd0, out_pc}, 64'd0);
      check_val("fl_ready", {63'd0, in_ready}, 64'd1);
      out_ready = 1;
      repeat (3) tick();
      check_val("fl_gone", {63'd0, out_valid}, 64'd0);

      // SKID=0: combinational ready, simultaneous accept and send
      out0_ready = 0;
      in0_valid = 1; in0_pc = 32'h31; in0_instr = 32'hD1;
      tick();
      check_val("s0_ready0", {63'd0, in0_ready}, 64'd0);
      in0_pc = 32'h32; in0_instr = 32'hD2; out0_ready = 1;
      #1;
      check_val("s0_ready1", {63'd0, in0_ready}, 64'd1);
      tick();
      check_val("s0_valid", {63'd0, out0_valid}, 64'd1);
      check_val("s0_instr", {32'd0, out0_instr}, {32'd0, 32'hD2});
      in0_valid = 0;
      tick();
      check_val("s0_empty", {63'd0, out0_valid}, 64'd0);

      // Reset asserted mid-transfer, then accept on first edge after release
      out_ready = 0;
      in_valid = 1; in_pc = 32'h41; in_instr = 32'hE1;
      tick();
      in_valid = 0;
      #1 Reset = 1'b0;
      #1;
      check_val("mr_valid", {63'd0, out_valid}, 64'd0);
      check_val("mr_instr", {32'd0, out_instr}, {32'd0, NOP});
      check_val("mr_bub", {48'd0, bubble_cnt}, 64'd0);
      @(posedge Clk);
      #1 Reset = 1'b1;
      in_valid = 1; in_pc = 32'h42; in_instr = 32'hE2; out_ready = 1;
      tick();
      in_valid = 0;
      check_val("mr_accept", {32'd0, out_instr}, {32'd0, 32'hE2});
      repeat (3) tick();

      check_val("bub1_model", {48'd0, bubble_cnt}, {48'd0, m_bub1});
      check_val("bub0_model", {60'd0, bubble0_cnt}, {60'd0, m_bub0});
      check_val("sb1_left", 64'(q1.size()), 64'd0);
      check_val("sb0_left", 64'(q0.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
